// File: rtl/delay_timer_multi.sv
// ============================================================================
// Module   : delay_timer_multi
// Purpose  : NCH independent one-shot/periodic delay timers with sticky
//            overrun flags, sharing one clock and one config port.
//            Optional shared prescaler: define DELAY_TIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_timer_multi #(
  parameter int NCH        = 4,
  parameter int CBITS      = 15,
  parameter int DEF_PERIOD = 17500,
  parameter int CHW        = 2
`ifdef DELAY_TIMER_PRESCALE_EN
  ,
  parameter int PSC_BITS   = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  input  logic [NCH-1:0]   err_clr,
`ifdef DELAY_TIMER_PRESCALE_EN
  input  logic [PSC_BITS-1:0] psc_div,
`endif
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   err
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic w_tick;

`ifdef DELAY_TIMER_PRESCALE_EN
  logic [PSC_BITS-1:0] r_psc;

  assign w_tick = (r_psc == psc_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= '0;
    end else if (w_tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + PSC_BITS'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic             r_state;
      logic [CBITS-1:0] r_cnt;
      logic [CBITS-1:0] r_period;
      logic             r_oneshot;
      logic             r_sig;
      logic             r_err;

      logic             w_state_nxt;
      logic [CBITS-1:0] w_cnt_nxt;
      logic             w_tc;
      logic             w_ovf;
      logic             w_sig_nxt;
      logic             w_err_nxt;
      logic             w_cfg_hit;

      // Widened compare so an out-of-range cfg_ch can never alias a channel.
      assign w_cfg_hit = cfg_we && (32'(cfg_ch) == i);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_period  <= CBITS'(DEF_PERIOD);
          r_oneshot <= 1'b0;
          r_sig     <= 1'b0;
          r_err     <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_sig   <= w_sig_nxt;
          r_err   <= w_err_nxt;
          if (w_cfg_hit) begin
            r_period  <= cfg_period;
            r_oneshot <= cfg_oneshot;
          end
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc        = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
          S_IDLE: begin
            if (start[i] && !stop[i]) begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = '0;
            end
          end
          S_RUN: begin
            if (stop[i]) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else if (start[i]) begin
              w_cnt_nxt = '0;
            end else if (w_tick) begin
              if (r_cnt < r_period) begin
                w_cnt_nxt = r_cnt + CBITS'(1);
              end else begin
                // cnt above period only happens after a mid-run period cut
                w_cnt_nxt = '0;
                w_tc      = (r_cnt == r_period);
                w_ovf     = (r_cnt != r_period);
                if (r_oneshot) begin
                  w_state_nxt = S_IDLE;
                end
              end
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      always_comb begin
        w_sig_nxt = w_tc;
        w_err_nxt = w_ovf | (r_err & ~err_clr[i]);
      end

      assign sig[i]  = r_sig;
      assign busy[i] = (r_state == S_RUN);
      assign err[i]  = r_err;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_delay_timer_multi.sv
// ============================================================================
// Module   : tb_delay_timer_multi
// Purpose  : Table-driven directed bench for delay_timer_multi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_timer_multi;
  localparam int NCH        = 4;
  localparam int CBITS      = 15;
  localparam int DEF_PERIOD = 17500;
  localparam int CHW        = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [CBITS-1:0] cfg_period;
  logic             cfg_oneshot;
  logic [NCH-1:0]   start, stop, err_clr;
  logic [NCH-1:0]   sig, busy, err;
`ifdef DELAY_TIMER_PRESCALE_EN
  logic [3:0]       psc_div;
`endif

  always #5 clk = ~clk;

  delay_timer_multi #(
    .NCH(NCH), .CBITS(CBITS), .DEF_PERIOD(DEF_PERIOD), .CHW(CHW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .err_clr(err_clr),
`ifdef DELAY_TIMER_PRESCALE_EN
    .psc_div(psc_div),
`endif
    .sig(sig), .busy(busy), .err(err)
  );

  typedef struct {
    logic [NCH-1:0]   st;
    logic [NCH-1:0]   sp;
    logic             we;
    logic [CHW-1:0]   ch;
    logic [CBITS-1:0] per;
    logic             os;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   esig;
    logic [NCH-1:0]   ebusy;
    logic [NCH-1:0]   eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d (0x%0h) expected %0d (0x%0h)", name, idx, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic [NCH-1:0] st, input logic [NCH-1:0] sp, input logic we,
                     input int ch, input int per, input logic os, input logic [NCH-1:0] clr,
                     input logic [NCH-1:0] es, input logic [NCH-1:0] eb, input logic [NCH-1:0] ee);
    vec_t v;
    v.st = st; v.sp = sp; v.we = we; v.ch = CHW'(ch); v.per = CBITS'(per); v.os = os;
    v.clr = clr; v.esig = es; v.ebusy = eb; v.eerr = ee;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 1'b0;
    start = '0; stop = '0; err_clr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    rst = 1'b1;
    idle_inputs();
`ifdef DELAY_TIMER_PRESCALE_EN
    psc_div = 4'd0;
`endif
    step(); step();
    check("reset_sig", 0, 32'(sig), 0);
    check("reset_busy", 0, 32'(busy), 0);
    check("reset_err", 0, 32'(err), 0);
    rst = 1'b0;

    // ch1 one-shot, period 3
    add(4'h0, 4'h0, 1, 1, 3, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h2, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h0);
    for (int k = 0; k < 3; k++) add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch3 period 0 periodic, then start+stop together
    add(4'h0, 4'h0, 1, 3, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h8, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h8, 4'h8, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h8, 4'h8, 4'h0);
    add(4'h8, 4'h8, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // out-of-range cfg_ch must not touch ch0 (still 17500)
    add(4'h0, 4'h0, 1, 4, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 overrun: period 10, lowered to 4 at cnt 7; set beats clear
    add(4'h0, 4'h0, 1, 2, 10, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h4, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
    for (int k = 0; k < 7; k++) add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h0, 4'h0, 1, 2, 4, 0, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h4, 4'h0, 4'h4, 4'h4);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h4);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h4, 4'h0, 4'h4, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0);
    add(4'h0, 4'h4, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch0 period 5 with retrigger at cnt 4
    add(4'h0, 4'h0, 1, 0, 5, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    for (int k = 0; k < 4; k++) add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    for (int k = 0; k < 5; k++) add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0);
    add(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h0);

    foreach (vecs[k]) begin
      start = vecs[k].st; stop = vecs[k].sp; cfg_we = vecs[k].we; cfg_ch = vecs[k].ch;
      cfg_period = vecs[k].per; cfg_oneshot = vecs[k].os; err_clr = vecs[k].clr;
      step();
      check("vec_sig", k, 32'(sig), 32'(vecs[k].esig));
      check("vec_busy", k, 32'(busy), 32'(vecs[k].ebusy));
      check("vec_err", k, 32'(err), 32'(vecs[k].eerr));
    end
    idle_inputs();

    // reset while ch0 runs, with start asserted: reset dominates
    rst = 1'b1; start = 4'hF;
    step();
    check("midrst_sig", 0, 32'(sig), 0);
    check("midrst_busy", 0, 32'(busy), 0);
    check("midrst_err", 0, 32'(err), 0);
    rst = 1'b0; start = '0;
    step();

    // default period restored: pulses every DEF_PERIOD+1 cycles
    start = 4'h1;
    step();
    start = '0;
    for (int p = 0; p < 2; p++) begin
      got = -1;
      for (int n = 1; n <= 20000; n++) begin
        step();
        if (sig[0]) begin
          got = n;
          break;
        end
      end
      check("def_period_latency", p, 32'(got), 32'(DEF_PERIOD + 1));
      check("def_period_err", p, 32'(err), 0);
    end
    step();
    check("def_pulse_width", 0, 32'(sig), 0);

`ifdef DELAY_TIMER_PRESCALE_EN
    start = '0; stop = 4'h1;
    step();
    stop = '0;
    psc_div = 4'd1;
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = 15'd3; cfg_oneshot = 1'b0; start = 4'h2;
    step();
    idle_inputs();
    got = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (sig[1]) begin
        got = n;
        break;
      end
    end
    check("psc_first_seen", 0, 32'(got > 0), 1);
    got = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (sig[1]) begin
        got = n;
        break;
      end
    end
    check("psc_interval", 0, 32'(got), 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
